// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
//   Parametrised single-clock synchronous FIFO with registered read data,
//   read-valid strobe, almost-full/almost-empty thresholds and sticky
//   overflow/underflow error flags. A write to a full FIFO is accepted when
//   a read is accepted in the same cycle.
//
// Parameters
//   DATA_WIDTH : entry width in bits
//   ADDR_WIDTH : pointer width; DEPTH = 2**ADDR_WIDTH entries
//   AF_LEVEL   : almost_full when fifo_counter >= AF_LEVEL  (1..DEPTH)
//   AE_LEVEL   : almost_empty when fifo_counter <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk          : clock, all state updates on rising edge
//   rst          : synchronous active-low reset
//   wr_en/buf_in : write request and data
//   rd_en        : read request
//   buf_out      : registered read data, holds value between reads
//   rd_valid     : one-cycle pulse when buf_out carries newly read data
//   buf_empty, buf_full, almost_empty, almost_full : decodes of fifo_counter
//   fifo_counter : occupancy 0..DEPTH
//   overflow     : sticky, a write was rejected
//   underflow    : sticky, a read was rejected
// ---------------------------------------------------------------------------
module fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] buf_in,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  rd_valid,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fifo_counter,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Counter-width versions of the constants keep every compare width-matched.
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] buf_out_q, buf_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic rd_acc;
    logic wr_acc;

    // Status decodes of the registered occupancy.
    assign buf_empty    = (count_q == '0);
    assign buf_full     = (count_q == DEPTH_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign almost_full  = (count_q >= AF_CNT);

    // A read frees a slot this cycle, so a full FIFO may still take a write.
    assign rd_acc = rd_en && !buf_empty;
    assign wr_acc = wr_en && (!buf_full || rd_acc);

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        buf_out_d   = buf_out_q;
        rd_valid_d  = rd_acc;
        overflow_d  = overflow_q  || (wr_en && !wr_acc);
        underflow_d = underflow_q || (rd_en && !rd_acc);

        // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            buf_out_d = mem[rd_ptr_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            buf_out_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            buf_out_q   <= buf_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and counter define
    // which entries are valid, so its contents never matter after reset.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem[wr_ptr_q] <= buf_in;
        end
    end

    assign buf_out      = buf_out_q;
    assign rd_valid     = rd_valid_q;
    assign fifo_counter = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_param
//   Directed self-checking bench for fifo_param at its default parameters
//   (8-bit data, 8 entries, AF_LEVEL=6, AE_LEVEL=2). Inputs change and outputs
//   are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] buf_in = 8'h00;
    logic [7:0] buf_out;
    logic       rd_valid;
    logic       buf_empty;
    logic       buf_full;
    logic       almost_empty;
    logic       almost_full;
    logic [3:0] fifo_counter;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;

    fifo_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_in       (buf_in),
        .buf_out      (buf_out),
        .rd_valid     (rd_valid),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_counter (fifo_counter),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic cycle(input logic wr, input logic rd, input logic [7:0] din);
        wr_en  = wr;
        rd_en  = rd;
        buf_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        idle();
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] v;

        // 1. Reset then idle
        do_reset();
        repeat (3) idle();
        check("rst_empty",    buf_empty,    1);
        check("rst_ae",       almost_empty, 1);
        check("rst_full",     buf_full,     0);
        check("rst_af",       almost_full,  0);
        check("rst_count",    fifo_counter, 0);
        check("rst_buf_out",  buf_out,      0);
        check("rst_rd_valid", rd_valid,     0);
        check("rst_overflow", overflow,     0);
        check("rst_underflow",underflow,    0);

        // 2. Fill with 0x11..0x88, overflow on ninth write, drain in order
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i * 8'h11);
            cycle(1'b1, 1'b0, v);
            check("fill_count", fifo_counter, i);
            check("fill_af",    almost_full,  (i >= 6) ? 1 : 0);
            check("fill_full",  buf_full,     (i == 8) ? 1 : 0);
        end
        check("fill_overflow_pre", overflow, 0);
        cycle(1'b1, 1'b0, 8'h99);
        check("ovf_count", fifo_counter, 8);
        check("ovf_flag",  overflow,     1);
        check("ovf_no_uf", underflow,    0);
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i * 8'h11);
            cycle(1'b0, 1'b1, 8'h00);
            check("drain_data",  buf_out,      v);
            check("drain_valid", rd_valid,     1);
            check("drain_count", fifo_counter, 8 - i);
        end
        idle();
        check("drain_valid_off", rd_valid,  0);
        check("drain_hold",      buf_out,   8'h88);
        check("drain_empty",     buf_empty, 1);

        // 3. Read on empty, then simultaneous write/read on empty
        cycle(1'b0, 1'b1, 8'h00);
        check("uf_valid",   rd_valid,  0);
        check("uf_hold",    buf_out,   8'h88);
        check("uf_flag",    underflow, 1);
        cycle(1'b1, 1'b1, 8'hA5);
        check("wr_on_empty_count", fifo_counter, 1);
        check("wr_on_empty_empty", buf_empty,    0);
        check("wr_on_empty_valid", rd_valid,     0);
        check("wr_on_empty_nobyp", buf_out,      8'h88);
        cycle(1'b0, 1'b1, 8'h00);
        check("a5_data",  buf_out,      8'hA5);
        check("a5_count", fifo_counter, 0);

        // 4. Full FIFO with simultaneous read/write
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
        check("full4_full", buf_full, 1);
        cycle(1'b1, 1'b1, 8'hC3);
        check("rw_full_data",     buf_out,      8'h40);
        check("rw_full_valid",    rd_valid,     1);
        check("rw_full_count",    fifo_counter, 8);
        check("rw_full_overflow", overflow,     0);
        for (int i = 1; i <= 8; i++) begin
            v = (i == 8) ? 8'hC3 : 8'(8'h40 + i);
            cycle(1'b0, 1'b1, 8'h00);
            check("rw_drain_data", buf_out, v);
        end
        check("rw_drain_empty", buf_empty, 1);
        check("rw_drain_uf",    underflow, 0);

        // 5. Wrap-around with almost_empty tracking
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h50 + i));
            check("wrap_w5_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("wrap_r5_data", buf_out,      8'(8'h50 + i));
            check("wrap_r5_ae",   almost_empty, (4 - i <= 2) ? 1 : 0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        check("wrap_w6_count", fifo_counter, 6);
        check("wrap_w6_af",    almost_full,  1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("wrap_r6_data", buf_out, 8'(8'h60 + i));
        end

        // 6. Reset mid-operation
        cycle(1'b0, 1'b1, 8'h00);
        check("pre_rst_uf", underflow, 1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h71 + i));
        check("pre_rst_count", fifo_counter, 4);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 8'hEE);
        rst = 1'b1;
        check("mid_rst_count", fifo_counter, 0);
        check("mid_rst_out",   buf_out,      0);
        check("mid_rst_valid", rd_valid,     0);
        check("mid_rst_uf",    underflow,    0);
        check("mid_rst_ovf",   overflow,     0);
        check("mid_rst_empty", buf_empty,    1);
        idle();
        check("post_rst_idle_count", fifo_counter, 0);
        cycle(1'b1, 1'b0, 8'hD1);
        cycle(1'b1, 1'b0, 8'hD2);
        check("post_rst_count", fifo_counter, 2);
        cycle(1'b0, 1'b1, 8'h00);
        check("post_rst_d1", buf_out, 8'hD1);
        cycle(1'b0, 1'b1, 8'h00);
        check("post_rst_d2", buf_out, 8'hD2);
        check("post_rst_empty", buf_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
